victim_swap_ctrl: RTL and testbench

- L1 dcache-side initiator for the victim cache.
- On an L1 miss it issues the two-cycle victim lookup and drives the physical tag in the second cycle.
- It then pushes the L1 evicted block into the victim cache through the store port and returns the fill result to L1.
- A hit means refill from the victim cache; a miss means the request goes on to L2.

---
 rtl/victim_pkg.sv | 29 ++
 rtl/vswap_sat_counter.sv | 31 +++
 rtl/victim_swap_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_victim_swap_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_pkg.sv
// rtl/victim_pkg.sv - shared widths, FSM state and victim-entry types for the victim swap controller
package victim_pkg;

    localparam int ADDR_W = 12;
    localparam int TAG_W  = 44;
    localparam int IDX_W  = 6;
    localparam int BLK_W  = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOOK1 = 3'd1,
        LOOK2 = 3'd2,
        PUSH  = 3'd3,
        RESP  = 3'd4
    } vswap_state_t;

    typedef struct packed {
        logic [BLK_W-1:0] data;
        logic [TAG_W-1:0] ptag;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } evict_info_t;

    // Index bits sit directly above the block offset in the untagged address.
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: IDX_W];
    endfunction

endpackage

// File: rtl/vswap_sat_counter.sv
// rtl/vswap_sat_counter.sv - saturating event counter, cleared by reset
module vswap_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/victim_swap_ctrl.sv
// rtl/victim_swap_ctrl.sv - L1-side victim cache lookup, evict push and fill return
// Optional perf counters (perf_hits, perf_lookups) under VICTIM_SWAP_PERF_EN.
module victim_swap_ctrl
    import victim_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [TAG_W-1:0]  miss_ptag,
    input  logic              miss_tlb_miss,
    input  logic              evict_valid,
    input  logic [BLK_W-1:0]  evict_data,
    input  logic [TAG_W-1:0]  evict_ptag,
    input  logic [IDX_W-1:0]  evict_idx,
    output logic [ADDR_W-1:0] vc_addr,
    output logic [TAG_W-1:0]  vc_ptag,
    output logic              vc_tlb_miss,
    input  logic              vc_found,
    input  logic [BLK_W-1:0]  vc_data,
    output logic              vc_wr_en,
    output logic [BLK_W-1:0]  vc_wr_data,
    output logic [TAG_W-1:0]  vc_wr_tag,
    output logic [IDX_W-1:0]  vc_wr_idx,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic              fill_hit,
    output logic [BLK_W-1:0]  fill_data
`ifdef VICTIM_SWAP_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_lookups
`endif
);

    vswap_state_t      state_q, state_d;
    logic [TAG_W-1:0]  ptag_q, ptag_d;
    logic              tlb_miss_q, tlb_miss_d;
    evict_info_t       evict_q, evict_d;

    logic [ADDR_W-1:0] vc_addr_q, vc_addr_d;
    logic [TAG_W-1:0]  vc_ptag_q, vc_ptag_d;
    logic              vc_tlb_miss_q, vc_tlb_miss_d;
    logic              vc_wr_en_q, vc_wr_en_d;
    logic [BLK_W-1:0]  vc_wr_data_q, vc_wr_data_d;
    logic [TAG_W-1:0]  vc_wr_tag_q, vc_wr_tag_d;
    logic [IDX_W-1:0]  vc_wr_idx_q, vc_wr_idx_d;
    logic              fill_valid_q, fill_valid_d;
    logic              fill_hit_q, fill_hit_d;
    logic [BLK_W-1:0]  fill_data_q, fill_data_d;

    logic accept;
    logic hit;

    assign accept = (state_q == IDLE) && miss_valid;
    assign hit    = vc_found && !tlb_miss_q;

    always_comb begin
        state_d       = state_q;
        ptag_d        = ptag_q;
        tlb_miss_d    = tlb_miss_q;
        evict_d       = evict_q;
        vc_addr_d     = vc_addr_q;
        vc_ptag_d     = vc_ptag_q;
        vc_tlb_miss_d = 1'b0;
        vc_wr_en_d    = 1'b0;
        vc_wr_data_d  = vc_wr_data_q;
        vc_wr_tag_d   = vc_wr_tag_q;
        vc_wr_idx_d   = vc_wr_idx_q;
        fill_valid_d  = fill_valid_q;
        fill_hit_d    = fill_hit_q;
        fill_data_d   = fill_data_q;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    ptag_d        = miss_ptag;
                    tlb_miss_d    = miss_tlb_miss;
                    evict_d.data  = evict_data;
                    evict_d.ptag  = evict_ptag;
                    evict_d.idx   = evict_idx;
                    evict_d.valid = evict_valid;
                    vc_addr_d     = miss_addr;
                    vc_tlb_miss_d = miss_tlb_miss;
                    state_d       = LOOK1;
                end
            end
            LOOK1: begin
                vc_ptag_d = ptag_q;
                state_d   = LOOK2;
            end
            LOOK2: begin
                // Block is captured here so the following PUSH may safely replace the hit entry.
                fill_hit_d  = hit;
                fill_data_d = hit ? vc_data : '0;
                if (evict_q.valid) begin
                    vc_wr_en_d   = 1'b1;
                    vc_wr_data_d = evict_q.data;
                    vc_wr_tag_d  = evict_q.ptag;
                    vc_wr_idx_d  = evict_q.idx;
                    state_d      = PUSH;
                end else begin
                    fill_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            PUSH: begin
                fill_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (fill_ready) begin
                    fill_valid_d = 1'b0;
                    fill_hit_d   = 1'b0;
                    fill_data_d  = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptag_q        <= '0;
            tlb_miss_q    <= 1'b0;
            evict_q       <= '0;
            vc_addr_q     <= '0;
            vc_ptag_q     <= '0;
            vc_tlb_miss_q <= 1'b0;
            vc_wr_en_q    <= 1'b0;
            vc_wr_data_q  <= '0;
            vc_wr_tag_q   <= '0;
            vc_wr_idx_q   <= '0;
            fill_valid_q  <= 1'b0;
            fill_hit_q    <= 1'b0;
            fill_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptag_q        <= ptag_d;
            tlb_miss_q    <= tlb_miss_d;
            evict_q       <= evict_d;
            vc_addr_q     <= vc_addr_d;
            vc_ptag_q     <= vc_ptag_d;
            vc_tlb_miss_q <= vc_tlb_miss_d;
            vc_wr_en_q    <= vc_wr_en_d;
            vc_wr_data_q  <= vc_wr_data_d;
            vc_wr_tag_q   <= vc_wr_tag_d;
            vc_wr_idx_q   <= vc_wr_idx_d;
            fill_valid_q  <= fill_valid_d;
            fill_hit_q    <= fill_hit_d;
            fill_data_q   <= fill_data_d;
        end
    end

    assign miss_ready  = (state_q == IDLE);
    assign vc_addr     = vc_addr_q;
    assign vc_ptag     = vc_ptag_q;
    assign vc_tlb_miss = vc_tlb_miss_q;
    assign vc_wr_en    = vc_wr_en_q;
    assign vc_wr_data  = vc_wr_data_q;
    assign vc_wr_tag   = vc_wr_tag_q;
    assign vc_wr_idx   = vc_wr_idx_q;
    assign fill_valid  = fill_valid_q;
    assign fill_hit    = fill_hit_q;
    assign fill_data   = fill_data_q;

`ifdef VICTIM_SWAP_PERF_EN
    vswap_sat_counter #(.W(32)) u_perf_lookups (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (perf_lookups)
    );

    vswap_sat_counter #(.W(32)) u_perf_hits (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_q == LOOK2) && hit),
        .count (perf_hits)
    );
`endif

    // An evicted line matching the missed line would have been an L1 hit.
    a_no_self_evict: assert property (@(posedge clk) disable iff (!reset)
        (accept && evict_valid) |-> !((evict_ptag == miss_ptag) && (evict_idx == idx_of(miss_addr))));

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// tb/tb_victim_swap_ctrl.sv - directed self-checking bench for victim_swap_ctrl
module tb_victim_swap_ctrl;

    logic         clk;
    logic         reset;
    logic         miss_valid;
    logic         miss_ready;
    logic [11:0]  miss_addr;
    logic [43:0]  miss_ptag;
    logic         miss_tlb_miss;
    logic         evict_valid;
    logic [511:0] evict_data;
    logic [43:0]  evict_ptag;
    logic [5:0]   evict_idx;
    logic [11:0]  vc_addr;
    logic [43:0]  vc_ptag;
    logic         vc_tlb_miss;
    logic         vc_found;
    logic [511:0] vc_data;
    logic         vc_wr_en;
    logic [511:0] vc_wr_data;
    logic [43:0]  vc_wr_tag;
    logic [5:0]   vc_wr_idx;
    logic         fill_valid;
    logic         fill_ready;
    logic         fill_hit;
    logic [511:0] fill_data;
`ifdef VICTIM_SWAP_PERF_EN
    logic [31:0]  perf_hits;
    logic [31:0]  perf_lookups;
`endif

    int n_checks;
    int n_fail;
    int wr_pulses;

    logic [511:0] pat_a;
    logic [511:0] pat_b;
    logic [511:0] pat_e;

    victim_swap_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .miss_ptag     (miss_ptag),
        .miss_tlb_miss (miss_tlb_miss),
        .evict_valid   (evict_valid),
        .evict_data    (evict_data),
        .evict_ptag    (evict_ptag),
        .evict_idx     (evict_idx),
        .vc_addr       (vc_addr),
        .vc_ptag       (vc_ptag),
        .vc_tlb_miss   (vc_tlb_miss),
        .vc_found      (vc_found),
        .vc_data       (vc_data),
        .vc_wr_en      (vc_wr_en),
        .vc_wr_data    (vc_wr_data),
        .vc_wr_tag     (vc_wr_tag),
        .vc_wr_idx     (vc_wr_idx),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_hit      (fill_hit),
        .fill_data     (fill_data)
`ifdef VICTIM_SWAP_PERF_EN
        ,
        .perf_hits     (perf_hits),
        .perf_lookups  (perf_lookups)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && vc_wr_en) wr_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input logic [11:0] a, input logic [43:0] pt, input logic tlb,
                             input logic ev, input logic [43:0] ept, input logic [5:0] eidx,
                             input logic [511:0] edata);
        miss_addr     = a;
        miss_ptag     = pt;
        miss_tlb_miss = tlb;
        evict_valid   = ev;
        evict_ptag    = ept;
        evict_idx     = eidx;
        evict_data    = edata;
        miss_valid    = 1'b1;
        @(posedge clk); #1;
        miss_valid    = 1'b0;
        evict_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (vc_addr !== 12'h0) begin n_fail++; $display("FAIL rst_vc_addr: got %h expected 0", vc_addr); end
        n_checks++; if (vc_ptag !== 44'h0) begin n_fail++; $display("FAIL rst_vc_ptag: got %h expected 0", vc_ptag); end
        n_checks++; if ({vc_tlb_miss, vc_wr_en, fill_valid, fill_hit} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {vc_tlb_miss, vc_wr_en, fill_valid, fill_hit}); end
        n_checks++; if (fill_data !== '0) begin n_fail++; $display("FAIL rst_fill_data: got %h expected 0", fill_data); end
        reset = 1'b1;
        #1;
        n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL rst_miss_ready: got %b expected 1", miss_ready); end
        wr_pulses = 0;
        vc_found = 1'b1;
        vc_data  = pat_a;
        start_req(12'h080, 44'h5A5, 1'b0, 1'b1, 44'h111, 6'h07, pat_e);
        @(posedge clk); #1;
        n_checks++; if (vc_ptag !== 44'h5A5) begin n_fail++; $display("FAIL rst_look2_ptag: got %h expected 5a5", vc_ptag); end
        reset = 1'b0;
        #1;
        n_checks++; if ({vc_ptag, vc_addr} !== 56'h0) begin n_fail++; $display("FAIL rst_mid_clear: got %h expected 0", {vc_ptag, vc_addr}); end
        n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got %b expected 1", miss_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        vc_found = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL rst_no_wr: got %0d expected 0", wr_pulses); end
        n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_fill: got %b expected 0", fill_valid); end
    endtask

    task automatic test_hit_no_evict();
        wr_pulses = 0;
        vc_found  = 1'b1;
        vc_data   = pat_a;
        start_req(12'h0C4, 44'hABC, 1'b0, 1'b0, 44'h0, 6'h0, '0);
        n_checks++; if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL hit_busy: got %b expected 0", miss_ready); end
        n_checks++; if (vc_addr !== 12'h0C4) begin n_fail++; $display("FAIL hit_vc_addr: got %h expected 0c4", vc_addr); end
        n_checks++; if (vc_tlb_miss !== 1'b0) begin n_fail++; $display("FAIL hit_tlb: got %b expected 0", vc_tlb_miss); end
        @(posedge clk); #1;
        n_checks++; if (vc_ptag !== 44'hABC) begin n_fail++; $display("FAIL hit_vc_ptag: got %h expected abc", vc_ptag); end
        n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL hit_early_fill: got %b expected 0", fill_valid); end
        @(posedge clk); #1;
        vc_found = 1'b0;
        vc_data  = '0;
        n_checks++; if (fill_valid !== 1'b1) begin n_fail++; $display("FAIL hit_fill_e2: got %b expected 1", fill_valid); end
        n_checks++; if (fill_hit !== 1'b1) begin n_fail++; $display("FAIL hit_fill_hit: got %b expected 1", fill_hit); end
        n_checks++; if (fill_data !== pat_a) begin n_fail++; $display("FAIL hit_fill_data: got %h expected %h", fill_data, pat_a); end
        @(posedge clk); #1;
        n_checks++; if ({fill_valid, miss_ready} !== 2'b01) begin n_fail++; $display("FAIL hit_done: got %b expected 01", {fill_valid, miss_ready}); end
        n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL hit_no_wr: got %0d expected 0", wr_pulses); end
    endtask

    task automatic test_miss_evict();
        wr_pulses = 0;
        vc_found  = 1'b0;
        vc_data   = pat_b;
        start_req(12'h100, 44'h456, 1'b0, 1'b1, 44'h123, 6'h05, pat_e);
        @(posedge clk); #1;
        n_checks++; if (vc_wr_en !== 1'b0) begin n_fail++; $display("FAIL ev_wr_early: got %b expected 0", vc_wr_en); end
        @(posedge clk); #1;
        n_checks++; if (vc_wr_en !== 1'b1) begin n_fail++; $display("FAIL ev_wr_en: got %b expected 1", vc_wr_en); end
        n_checks++; if ({vc_wr_tag, vc_wr_idx} !== {44'h123, 6'h05}) begin n_fail++; $display("FAIL ev_wr_tag_idx: got %h expected %h", {vc_wr_tag, vc_wr_idx}, {44'h123, 6'h05}); end
        n_checks++; if (vc_wr_data !== pat_e) begin n_fail++; $display("FAIL ev_wr_data: got %h expected %h", vc_wr_data, pat_e); end
        n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL ev_fill_e2: got %b expected 0", fill_valid); end
        @(posedge clk); #1;
        n_checks++; if (vc_wr_en !== 1'b0) begin n_fail++; $display("FAIL ev_wr_single: got %b expected 0", vc_wr_en); end
        n_checks++; if ({fill_valid, fill_hit} !== 2'b10) begin n_fail++; $display("FAIL ev_fill_e3: got %b expected 10", {fill_valid, fill_hit}); end
        n_checks++; if (fill_data !== '0) begin n_fail++; $display("FAIL ev_fill_data: got %h expected 0", fill_data); end
        @(posedge clk); #1;
        n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL ev_done: got %b expected 0", fill_valid); end
        n_checks++; if (wr_pulses !== 1) begin n_fail++; $display("FAIL ev_wr_count: got %0d expected 1", wr_pulses); end
    endtask

    task automatic test_tlb_miss();
        vc_found = 1'b1;
        vc_data  = pat_a;
        start_req(12'h2C0, 44'h777, 1'b1, 1'b0, 44'h0, 6'h0, '0);
        n_checks++; if (vc_tlb_miss !== 1'b1) begin n_fail++; $display("FAIL tlb_look1: got %b expected 1", vc_tlb_miss); end
        @(posedge clk); #1;
        n_checks++; if (vc_tlb_miss !== 1'b0) begin n_fail++; $display("FAIL tlb_look2: got %b expected 0", vc_tlb_miss); end
        @(posedge clk); #1;
        n_checks++; if ({fill_valid, fill_hit, vc_tlb_miss} !== 3'b100) begin n_fail++; $display("FAIL tlb_fill: got %b expected 100", {fill_valid, fill_hit, vc_tlb_miss}); end
        n_checks++; if (fill_data !== '0) begin n_fail++; $display("FAIL tlb_fill_data: got %h expected 0", fill_data); end
        @(posedge clk); #1;
        vc_found = 1'b0;
    endtask

    task automatic test_back_to_back();
        fill_ready = 1'b0;
        vc_found   = 1'b1;
        vc_data    = pat_b;
        start_req(12'h040, 44'h099, 1'b0, 1'b0, 44'h0, 6'h0, '0);
        repeat (2) @(posedge clk);
        #1;
        vc_found   = 1'b0;
        vc_data    = '0;
        miss_addr  = 12'h3C0;
        miss_ptag  = 44'h0AA;
        miss_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if ({fill_valid, fill_hit, miss_ready} !== 3'b110) begin n_fail++; $display("FAIL bp_hold_flags[%0d]: got %b expected 110", i, {fill_valid, fill_hit, miss_ready}); end
            n_checks++; if (fill_data !== pat_b) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, fill_data, pat_b); end
            n_checks++; if (vc_addr !== 12'h040) begin n_fail++; $display("FAIL bp_ignore[%0d]: got %h expected 040", i, vc_addr); end
        end
        fill_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({fill_valid, miss_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b expected 01", {fill_valid, miss_ready}); end
        n_checks++; if (vc_addr !== 12'h040) begin n_fail++; $display("FAIL bp_no_early_accept: got %h expected 040", vc_addr); end
        @(posedge clk); #1;
        miss_valid = 1'b0;
        n_checks++; if ({vc_addr, miss_ready} !== {12'h3C0, 1'b0}) begin n_fail++; $display("FAIL bp_second_accept: got %h expected %h", {vc_addr, miss_ready}, {12'h3C0, 1'b0}); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({fill_valid, fill_hit} !== 2'b10) begin n_fail++; $display("FAIL bp_second_fill: got %b expected 10", {fill_valid, fill_hit}); end
        @(posedge clk); #1;
    endtask

`ifdef VICTIM_SWAP_PERF_EN
    task automatic run_req(input logic found);
        vc_found = found;
        vc_data  = pat_a;
        start_req(12'h200, 44'h321, 1'b0, 1'b0, 44'h0, 6'h0, '0);
        repeat (3) @(posedge clk);
        #1;
        vc_found = 1'b0;
    endtask

    task automatic test_perf();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_req(1'b1);
        run_req(1'b0);
        run_req(1'b1);
        n_checks++; if (perf_lookups !== 32'd3) begin n_fail++; $display("FAIL perf_lookups: got %0d expected 3", perf_lookups); end
        n_checks++; if (perf_hits !== 32'd2) begin n_fail++; $display("FAIL perf_hits: got %0d expected 2", perf_hits); end
        dut.u_perf_hits.count_q = 32'hFFFF_FFFF;
        run_req(1'b1);
        n_checks++; if (perf_hits !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL perf_sat: got %h expected ffffffff", perf_hits); end
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        wr_pulses     = 0;
        pat_a         = {16{32'hDEADBEEF}};
        pat_b         = {16{32'h01234567}};
        pat_e         = {16{32'hCAFEF00D}};
        reset         = 1'b0;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        miss_ptag     = '0;
        miss_tlb_miss = 1'b0;
        evict_valid   = 1'b0;
        evict_data    = '0;
        evict_ptag    = '0;
        evict_idx     = '0;
        vc_found      = 1'b0;
        vc_data       = '0;
        fill_ready    = 1'b1;

        test_reset();
        test_hit_no_evict();
        test_miss_evict();
        test_tlb_miss();
        test_back_to_back();
`ifdef VICTIM_SWAP_PERF_EN
        test_perf();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
